braille_digit_sequencer: RTL

Upstream stage of the Braille digit decoder. Accepts a packed multi-digit BCD word over a valid/ready handshake and presents it as a timed sequence of Braille cells: a number-sign cell, then one BCD digit per cell (most significant first, leading zeros optionally suppressed), then a blank gap cell. The `bcd` output feeds the decoder's 4-bit BCD input directly. The flags tell the cell driver whether the decoded dots, the number sign or a blank cell applies.

---
 rtl/braille_digit_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/braille_digit_sequencer.sv
// Braille digit sequencer: turns a packed BCD word into timed cells
// (number sign, digits MSD first, blank gap) for the Braille decoder.
module braille_digit_sequencer #(
    parameter int DIGITS      = 4,
    parameter int DWELL       = 1000,
    parameter bit SUPPRESS_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic [3:0]            bcd,
    output logic                  cell_digit,
    output logic                  cell_num_sign,
    output logic                  cell_strobe,
    output logic                  busy,
    output logic                  err
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);
    localparam logic [IW-1:0] TOP_IDX  = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SIGN,
        DIGIT,
        GAP
    } state_t;

    state_t                  state;
    logic [DIGITS-1:0][3:0]  word;
    logic [DIGITS-1:0][3:0]  nib;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           start_idx;
    logic                    bad;

    assign nib      = in_bcd;
    assign in_ready = (state == IDLE);

    // Highest nonzero nibble wins; an all-zero word still shows digit 0.
    always_comb begin
        bad       = 1'b0;
        start_idx = SUPPRESS_LZ ? '0 : TOP_IDX;
        for (int i = 0; i < DIGITS; i++) begin
            if (nib[i] > 4'd9)
                bad = 1'b1;
            if (SUPPRESS_LZ && nib[i] != 4'd0)
                start_idx = IW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            word          <= '0;
            cnt           <= '0;
            idx           <= '0;
            bcd           <= 4'd0;
            cell_digit    <= 1'b0;
            cell_num_sign <= 1'b0;
            cell_strobe   <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
        end else begin
            err         <= 1'b0;
            cell_strobe <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        word <= nib;
                        if (bad) begin
                            err <= 1'b1;
                        end else begin
                            state         <= SIGN;
                            cnt           <= CNT_LOAD;
                            idx           <= start_idx;
                            busy          <= 1'b1;
                            cell_num_sign <= 1'b1;
                            cell_strobe   <= 1'b1;
                        end
                    end
                end
                SIGN: begin
                    if (cnt == '0) begin
                        state         <= DIGIT;
                        cnt           <= CNT_LOAD;
                        bcd           <= word[idx];
                        cell_num_sign <= 1'b0;
                        cell_digit    <= 1'b1;
                        cell_strobe   <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DIGIT: begin
                    if (cnt == '0) begin
                        cnt         <= CNT_LOAD;
                        cell_strobe <= 1'b1;
                        if (idx == '0) begin
                            state      <= GAP;
                            cell_digit <= 1'b0;
                        end else begin
                            idx <= idx - 1'b1;
                            bcd <= word[idx - 1'b1];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
